// File: rtl/sfc_layer_seq_pkg.sv
// sfc_pkg: shared definitions for the windowed stochastic fully-connected layer.
//   sfc_state_e : sequencer states (IDLE, ACCUM, LATCH)
//   P_W         : width of the output firing probability and of the rng word
//   sat_add     : symmetric saturating add of a signed step onto an accumulator
//   prob_map    : accumulator -> 8-bit firing probability (top 8 bits, offset by 128)
package sfc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LATCH = 2'd2
    } sfc_state_e;

    localparam int P_W = 8;

    // The clamp is symmetric (+/-(2^(acc_w-1)-1)) so that the most negative
    // code never appears and |acc| always fits in acc_w bits.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] acc,
        input logic signed [31:0] delta,
        input int                 acc_w
    );
        logic signed [31:0] sum;
        logic signed [31:0] lim;
        sum = acc + delta;
        lim = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
        if (sum > lim) begin
            return lim;
        end
        if (sum < -lim) begin
            return -lim;
        end
        return sum;
    endfunction

    // Arithmetic shift leaves a signed value in [-128, 127]; flipping the
    // top bit of its low byte is the same as adding 128.
    function automatic logic [P_W-1:0] prob_map(
        input logic signed [31:0] acc,
        input int                 acc_w
    );
        logic signed [31:0] sh;
        sh = acc >>> (acc_w - P_W);
        return P_W'(sh) ^ 8'h80;
    endfunction

endpackage

// File: rtl/sfc_layer_seq_if.sv
// sfc_layer_seq_if: control and data bundle of one sfc_layer_seq instance.
//   start, busy, done             : window handshake
//   a_in, alpha, sign_alpha       : input activations and per-neuron weight streams
//   beta, sign_beta, a_mem_active : per-neuron bias stream/sign and enable mask
//   rng                           : shared LFSR word for output stream generation
//   z, zp, a_out                  : latched sign/derivative flags and output streams
// master drives the inputs of the layer, slave is the layer itself.
interface sfc_layer_seq_if
    import sfc_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_OUT = 5
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [N_IN-1:0]         a_in;
    logic [N_OUT*N_IN-1:0]   alpha;
    logic [N_OUT*N_IN-1:0]   sign_alpha;
    logic [N_OUT-1:0]        beta;
    logic [N_OUT-1:0]        sign_beta;
    logic [N_OUT-1:0]        a_mem_active;
    logic [P_W-1:0]          rng;
    logic [N_OUT-1:0]        z;
    logic [N_OUT-1:0]        zp;
    logic [N_OUT-1:0]        a_out;

    modport master (
        output start, a_in, alpha, sign_alpha, beta, sign_beta, a_mem_active, rng,
        input  busy, done, z, zp, a_out
    );

    modport slave (
        input  start, a_in, alpha, sign_alpha, beta, sign_beta, a_mem_active, rng,
        output busy, done, z, zp, a_out
    );

endinterface

// File: rtl/sfc_layer_seq_neuron_acc.sv
// sfc_neuron_acc: one neuron of the stochastic layer.
//   CLK, INIT_n          : clock, synchronous active-low reset
//   clr                  : zero the accumulator (window start)
//   acc_en               : add this cycle's signed step (ACCUM)
//   latch                : capture z/zp/p from the accumulator (LATCH)
//   active               : dropout enable for this neuron
//   a_in, alpha, sign_alpha, beta, sign_beta : input, weight and bias streams
//   rng                  : shared random word compared against p
//   z, zp, a_out         : sign flag, derivative flag, output stream
module sfc_neuron_acc
    import sfc_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int ACC_W  = 12,
    parameter int ZP_THR = 16
) (
    input  logic            CLK,
    input  logic            INIT_n,
    input  logic            clr,
    input  logic            acc_en,
    input  logic            latch,
    input  logic            active,
    input  logic [N_IN-1:0] a_in,
    input  logic [N_IN-1:0] alpha,
    input  logic [N_IN-1:0] sign_alpha,
    input  logic            beta,
    input  logic            sign_beta,
    input  logic [P_W-1:0]  rng,
    output logic            z,
    output logic            zp,
    output logic            a_out
);

    logic signed [ACC_W-1:0] acc;
    logic [P_W-1:0]          p;
    logic signed [31:0]      delta;
    logic signed [31:0]      acc_ext;
    logic signed [31:0]      acc_abs;

    // Each firing input contributes +1 or -1 according to its weight sign;
    // the bias stream is one more term of the same kind.
    always_comb begin
        delta = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (a_in[i] && alpha[i]) begin
                delta = sign_alpha[i] ? delta - 32'sd1 : delta + 32'sd1;
            end
        end
        if (beta) begin
            delta = sign_beta ? delta - 32'sd1 : delta + 32'sd1;
        end
    end

    assign acc_ext = 32'(acc);
    assign acc_abs = (acc_ext < 0) ? -acc_ext : acc_ext;

    always_ff @(posedge CLK) begin
        if (!INIT_n) begin
            acc   <= '0;
            p     <= '0;
            z     <= 1'b0;
            zp    <= 1'b0;
            a_out <= 1'b0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= ACC_W'(sat_add(acc_ext, delta, ACC_W));
            end
            // p follows the accumulator even for a dropped neuron so that it
            // streams immediately once re-enabled.
            if (latch) begin
                z  <= active && (acc_ext > 0);
                zp <= active && (acc_abs <= ZP_THR);
                p  <= prob_map(acc_ext, ACC_W);
            end
            a_out <= active && (rng < p);
        end
    end

endmodule

// File: rtl/sfc_layer_seq.sv
// sfc_layer_seq: windowed stochastic fully-connected layer of N_OUT neurons
// over N_IN input streams. Each window accumulates 2^WIN_LOG2 cycles of signed
// weight/bias bitstreams per neuron, then latches z, zp and a new output
// probability which keeps driving a_out while the next window accumulates.
//   CLK    : clock
//   INIT_n : synchronous active-low reset
//   bus    : sfc_layer_seq_if.slave (start/busy/done, streams, z/zp/a_out)
// Build option:
//   SFC_FREERUN_EN : when defined, LATCH returns straight to ACCUM so windows
//                    run back to back after the first start; otherwise each
//                    window needs its own start.
//
// state | meaning
// IDLE  | waiting for start; outputs keep streaming from the last p
// ACCUM | accumulating one window, cnt counts 0 .. 2^WIN_LOG2-1
// LATCH | capture z/zp/p from the accumulators, done pulses next cycle
module sfc_layer_seq
    import sfc_pkg::*;
#(
    parameter int N_IN     = 8,
    parameter int N_OUT    = 5,
    parameter int ACC_W    = 12,
    parameter int WIN_LOG2 = 8,
    parameter int ZP_THR   = 16
) (
    input  logic             CLK,
    input  logic             INIT_n,
    sfc_layer_seq_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_ACCUM = 2'(ACCUM);
    localparam logic [1:0] S_LATCH = 2'(LATCH);

    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [WIN_LOG2-1:0] cnt;
    logic                clr;
    logic                acc_en;
    logic                latch;
    logic                busy_q;
    logic                done_q;
    logic [N_OUT-1:0]    z_v;
    logic [N_OUT-1:0]    zp_v;
    logic [N_OUT-1:0]    a_out_v;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
`ifdef SFC_FREERUN_EN
                state_nxt = S_ACCUM;
`else
                state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Clearing on the entry edge lets the first ACCUM cycle already add.
    assign clr    = (state_nxt == S_ACCUM) && (state != S_ACCUM);
    assign acc_en = (state == S_ACCUM);
    assign latch  = (state == S_LATCH);

    always_ff @(posedge CLK) begin
        if (!INIT_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != S_IDLE);
            done_q <= latch;
            if (clr) begin
                cnt <= '0;
            end else if (acc_en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        sfc_neuron_acc #(
            .N_IN   (N_IN),
            .ACC_W  (ACC_W),
            .ZP_THR (ZP_THR)
        ) u_neuron (
            .CLK        (CLK),
            .INIT_n     (INIT_n),
            .clr        (clr),
            .acc_en     (acc_en),
            .latch      (latch),
            .active     (bus.a_mem_active[j]),
            .a_in       (bus.a_in),
            .alpha      (bus.alpha[j*N_IN +: N_IN]),
            .sign_alpha (bus.sign_alpha[j*N_IN +: N_IN]),
            .beta       (bus.beta[j]),
            .sign_beta  (bus.sign_beta[j]),
            .rng        (bus.rng),
            .z          (z_v[j]),
            .zp         (zp_v[j]),
            .a_out      (a_out_v[j])
        );
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.z     = z_v;
    assign bus.zp    = zp_v;
    assign bus.a_out = a_out_v;

endmodule
